// File: rtl/regfile_op_sequencer.sv
// Table-driven stimulus master for the RegFile wrapper load interface: plays each op
// through the ld_Reg/ld_Setup/ld_Imm/ld_clk strobes, then checks aluOutput against op_expect.
module regfile_op_sequencer #(
    parameter int OP_COUNT      = 8,
    parameter int ADDR_W        = 3,
    parameter int HOLD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] op_addr,
    input  logic [9:0]        op_reg,
    input  logic [9:0]        op_setup,
    input  logic [9:0]        op_imm,
    input  logic [15:0]       op_expect,
    output logic [9:0]        data_input,
    output logic              ld_Reg,
    output logic              ld_Setup,
    output logic              ld_Imm,
    output logic              ld_clk,
    input  logic [15:0]       aluOutput,
    input  logic [4:0]        Flags,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_index,
    output logic [15:0]       last_result,
    output logic [4:0]        last_flags,
    output logic [7:0]        pass_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_REG, S_SETUP, S_IMM, S_CLK, S_SETTLE, S_CHECK, S_DONE
    } state_t;

    localparam logic [15:0] PHASE_LAST  = 16'(HOLD_CYCLES + 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OP_COUNT - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [9:0]        reg_q, reg_d, setup_q, setup_d, imm_q, imm_d;
    logic [15:0]       expect_q, expect_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] fail_index_q, fail_index_d;
    logic [15:0]       last_result_q, last_result_d;
    logic [4:0]        last_flags_q, last_flags_d;
    logic [7:0]        pass_count_q, pass_count_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_addr_q     <= '0;
            reg_q         <= '0;
            setup_q       <= '0;
            imm_q         <= '0;
            expect_q      <= '0;
            fail_q        <= 1'b0;
            fail_index_q  <= '0;
            last_result_q <= '0;
            last_flags_q  <= '0;
            pass_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_addr_q     <= op_addr_d;
            reg_q         <= reg_d;
            setup_q       <= setup_d;
            imm_q         <= imm_d;
            expect_q      <= expect_d;
            fail_q        <= fail_d;
            fail_index_q  <= fail_index_d;
            last_result_q <= last_result_d;
            last_flags_q  <= last_flags_d;
            pass_count_q  <= pass_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_addr_d     = op_addr_q;
        reg_d         = reg_q;
        setup_d       = setup_q;
        imm_d         = imm_q;
        expect_d      = expect_q;
        fail_d        = fail_q;
        fail_index_d  = fail_index_q;
        last_result_d = last_result_q;
        last_flags_d  = last_flags_q;
        pass_count_d  = pass_count_q;
        data_input    = '0;
        ld_Reg        = 1'b0;
        ld_Setup      = 1'b0;
        ld_Imm        = 1'b0;
        ld_clk        = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d      = S_FETCH;
                    cnt_d        = '0;
                    op_addr_d    = '0;
                    fail_d       = 1'b0;
                    fail_index_d = '0;
                    pass_count_d = '0;
                end
            end
            S_FETCH: begin
                state_d = S_REG;
                cnt_d   = '0;
            end
            S_REG: begin
                // Table output first becomes valid here; pass it straight through
                // while it is captured so the word is stable from the phase's first cycle.
                if (cnt_q == '0) begin
                    data_input = op_reg;
                    reg_d      = op_reg;
                    setup_d    = op_setup;
                    imm_d      = op_imm;
                    expect_d   = op_expect;
                end else begin
                    data_input = reg_q;
                end
                ld_Reg = (cnt_q != '0) && (cnt_q <= HOLD_LAST);
                cnt_d  = cnt_q + 16'd1;
                if (cnt_q == PHASE_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_SETUP: begin
                data_input = setup_q;
                ld_Setup   = (cnt_q != '0) && (cnt_q <= HOLD_LAST);
                cnt_d      = cnt_q + 16'd1;
                if (cnt_q == PHASE_LAST) begin
                    state_d = S_IMM;
                    cnt_d   = '0;
                end
            end
            S_IMM: begin
                data_input = imm_q;
                ld_Imm     = (cnt_q != '0) && (cnt_q <= HOLD_LAST);
                cnt_d      = cnt_q + 16'd1;
                if (cnt_q == PHASE_LAST) begin
                    state_d = S_CLK;
                    cnt_d   = '0;
                end
            end
            S_CLK: begin
                data_input = imm_q;
                ld_clk     = (cnt_q < HOLD_LAST);
                cnt_d      = cnt_q + 16'd1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                data_input = imm_q;
                cnt_d      = cnt_q + 16'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                data_input    = imm_q;
                last_result_d = aluOutput;
                last_flags_d  = Flags;
                if (aluOutput == expect_q) begin
                    if (pass_count_q != 8'hFF) pass_count_d = pass_count_q + 8'd1;
                end else if (!fail_q) begin
                    fail_d       = 1'b1;
                    fail_index_d = op_addr_q;
                end
                if (op_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    op_addr_d = op_addr_q + ADDR_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign op_addr     = op_addr_q;
    assign fail        = fail_q;
    assign fail_index  = fail_index_q;
    assign last_result = last_result_q;
    assign last_flags  = last_flags_q;
    assign pass_count  = pass_count_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer: random op tables, a synchronous-read table
// model, and monitors that check every strobe pulse and every run result.
module tb_regfile_op_sequencer;

    localparam int OPS    = 8;
    localparam int AW     = 3;
    localparam int HOLD   = 2;
    localparam int SETTLE = 2;
    localparam int PER_OP = 1 + 3 * (HOLD + 2) + (HOLD + 1) + SETTLE + 1;
    localparam int BUDGET = OPS * PER_OP + 50;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] op_addr;
    logic [9:0]    op_reg = '0, op_setup = '0, op_imm = '0;
    logic [15:0]   op_expect = '0;
    logic [9:0]    data_input;
    logic          ld_Reg, ld_Setup, ld_Imm, ld_clk;
    logic [15:0]   aluOutput;
    logic [4:0]    Flags;
    logic          busy, done, fail;
    logic [AW-1:0] fail_index;
    logic [15:0]   last_result;
    logic [4:0]    last_flags;
    logic [7:0]    pass_count;

    always #5 clk = ~clk;

    regfile_op_sequencer #(
        .OP_COUNT(OPS), .ADDR_W(AW), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op_addr(op_addr),
        .op_reg(op_reg), .op_setup(op_setup), .op_imm(op_imm), .op_expect(op_expect),
        .data_input(data_input), .ld_Reg(ld_Reg), .ld_Setup(ld_Setup), .ld_Imm(ld_Imm),
        .ld_clk(ld_clk), .aluOutput(aluOutput), .Flags(Flags), .busy(busy), .done(done),
        .fail(fail), .fail_index(fail_index), .last_result(last_result),
        .last_flags(last_flags), .pass_count(pass_count)
    );

    // Op table (one-cycle synchronous read) and the wrapper's response per op
    logic [9:0]  m_reg [OPS];
    logic [9:0]  m_setup [OPS];
    logic [9:0]  m_imm [OPS];
    logic [15:0] m_exp [OPS];
    logic [15:0] m_resp [OPS];
    logic [4:0]  m_flg [OPS];

    always @(posedge clk) begin
        op_reg    <= m_reg[op_addr];
        op_setup  <= m_setup[op_addr];
        op_imm    <= m_imm[op_addr];
        op_expect <= m_exp[op_addr];
    end
    assign aluOutput = m_resp[op_addr];
    assign Flags     = m_flg[op_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int runs  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [3:0] kind; logic [9:0] word; int gap; } strb_t;
    typedef struct {
        int done_cyc; logic [7:0] pc; logic f; logic [AW-1:0] fi; logic [15:0] lr; logic [4:0] lf;
    } run_t;
    strb_t sq[$];
    run_t  rq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: all match, 1: mismatches at ops 3 and 5, 2: random mismatches, 3: mode 0 with fixed op0
    task automatic fill(input int mode);
        for (int i = 0; i < OPS; i++) begin
            m_reg[i]   = 10'($urandom);
            m_setup[i] = 10'($urandom);
            m_imm[i]   = 10'($urandom);
            m_exp[i]   = 16'($urandom);
            m_flg[i]   = 5'($urandom);
            if (m_exp[i] == 16'hDEAD) m_exp[i] = 16'hDEAC;
            m_resp[i]  = m_exp[i];
            if (mode == 1 && (i == 3 || i == 5)) m_resp[i] = 16'hDEAD;
            if (mode == 2 && $urandom_range(0, 3) == 0)
                m_resp[i] = m_exp[i] ^ 16'($urandom_range(1, 65535));
        end
        if (mode == 3) begin
            m_reg[0]   = 10'h040;
            m_setup[0] = 10'h180;
            m_imm[0]   = 10'h100;
        end
    endtask

    // Expected strobe program and run outcome for the current table; set_cyc is the
    // cycle in which start is seen high by the edge that accepts it.
    task automatic push_run(input int set_cyc);
        int   first = -1;
        int   pc = 0;
        run_t r;
        for (int i = 0; i < OPS; i++) begin
            sq.push_back('{kind: 4'b0001, word: m_reg[i], gap: (i == 0) ? 2 : 6});
            sq.push_back('{kind: 4'b0010, word: m_setup[i], gap: 2});
            sq.push_back('{kind: 4'b0100, word: m_imm[i], gap: 2});
            sq.push_back('{kind: 4'b1000, word: m_imm[i], gap: 1});
            if (m_resp[i] == m_exp[i]) pc++;
            else if (first < 0) first = i;
        end
        r.done_cyc = set_cyc + 1 + OPS * PER_OP;
        r.pc       = 8'((pc > 255) ? 255 : pc);
        r.f        = (first >= 0);
        r.fi       = (first >= 0) ? AW'(first) : '0;
        r.lr       = m_resp[OPS-1];
        r.lf       = m_flg[OPS-1];
        rq.push_back(r);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < BUDGET) begin
            tick();
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: done not seen after %0d cycles, required within %0d", n, BUDGET);
        end
    endtask

    // Pulses start at random while the sequencer is mid-run (all must be ignored).
    task automatic wait_done_stray();
        int n = 0;
        while (!done && n < BUDGET) begin
            if (busy && $urandom_range(0, 11) == 0) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: done not seen after %0d cycles, required within %0d", n, BUDGET);
        end
    endtask

    task automatic launch(input int mode);
        fill(mode);
        push_run(cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Strobe and run monitor
    logic [3:0] mon_prev_s = '0, mon_kind = '0, s;
    logic [9:0] mon_prev_di = '0, mon_pre = '0, mon_di = '0;
    logic       mon_stable = 1'b0, mon_prev_done = 1'b0;
    int         mon_len = 0, mon_gap = 0, mon_rise_gap = 0;
    strb_t      e;
    run_t       r;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            sq.delete();
            rq.delete();
            mon_prev_s    = '0;
            mon_prev_di   = '0;
            mon_prev_done = 1'b0;
            mon_gap       = 0;
        end else begin
            s = {ld_clk, ld_Imm, ld_Setup, ld_Reg};
            if (s != '0) check("strobe_onehot_busy", {63'b0, $onehot(s)} << 1 | 64'(busy), 64'd3);
            if (mon_prev_s != '0 && s != mon_prev_s) begin
                if (sq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe_unexpected: pulse kind %b, none required", mon_kind);
                end else begin
                    e = sq.pop_front();
                    check("strobe_pulse",
                          {13'b0, mon_kind, 8'(mon_len), mon_pre, mon_di, data_input, mon_stable, 8'(mon_rise_gap)},
                          {13'b0, e.kind, 8'(HOLD), e.word, e.word, e.word, 1'b1, 8'(e.gap)});
                end
            end
            if (s != '0 && s != mon_prev_s) begin
                mon_kind     = s;
                mon_len      = 1;
                mon_pre      = mon_prev_di;
                mon_di       = data_input;
                mon_stable   = 1'b1;
                mon_rise_gap = mon_gap;
                mon_gap      = 0;
            end else if (s != '0) begin
                mon_len++;
                if (data_input != mon_di) mon_stable = 1'b0;
            end else if (busy) begin
                mon_gap++;
            end else begin
                mon_gap = 0;
            end

            if (done) begin
                check("done_single_pulse", 64'(mon_prev_done), 64'd0);
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: done at cyc %0d, no run outstanding", cyc);
                end else begin
                    r = rq.pop_front();
                    runs++;
                    check("run_result",
                          {pass_count, fail, fail_index, last_result, last_flags, busy},
                          {r.pc, r.f, r.fi, r.lr, r.lf, 1'b0});
                    check("run_latency", 64'(cyc), 64'(r.done_cyc));
                    $display("run %0d: pass_count=%0d fail=%0b fail_index=%0d last_result=%04h flags=%02h cyc=%0d",
                             runs, pass_count, fail, fail_index, last_result, last_flags, cyc);
                end
            end
            mon_prev_s    = s;
            mon_prev_di   = data_input;
            mon_prev_done = done;
        end
    end

    initial begin
        for (int i = 0; i < OPS; i++) begin
            m_reg[i] = '0; m_setup[i] = '0; m_imm[i] = '0;
            m_exp[i] = '0; m_resp[i] = '0; m_flg[i] = '0;
        end
        reset = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {op_addr, data_input, ld_Reg, ld_Setup, ld_Imm, ld_clk, busy, done, fail,
               fail_index, last_result, last_flags, pass_count}, 64'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_after_reset", {62'b0, busy, done}, 64'd0);

        // Fixed first op, all passing
        launch(3);
        wait_done();
        tick();
        check("idle_after_done", 64'(busy), 64'd0);

        // Mismatches at ops 3 and 5 with stray starts mid-run; then start held across
        // the DONE cycle and the following IDLE cycle, where only the latter may start a run.
        launch(1);
        wait_done_stray();
        fill(0);
        push_run(cyc + 1);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done();
        tick();

        for (int k = 0; k < 3; k++) begin
            launch(2);
            wait_done_stray();
            tick();
        end

        // Reset pulse while ld_Setup is high
        launch(0);
        begin
            int n = 0;
            while (!ld_Setup && n < 200) begin
                tick();
                n++;
            end
        end
        check("abort_setup_reached", 64'(ld_Setup), 64'd1);
        reset = 1'b0;
        tick();
        check("abort_outputs",
              {op_addr, data_input, ld_Reg, ld_Setup, ld_Imm, ld_clk, busy, done, fail,
               fail_index, last_result, last_flags, pass_count}, 64'd0);
        reset = 1'b1;
        tick();

        launch(1);
        wait_done();
        repeat (3) tick();
        check("scoreboard_drained", 64'(rq.size() + sq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
